// File: rtl/rst_seq_ctrl.sv
// Sequenced reset controller: synchronises rst_n, then releases NSTG stage resets in order,
// waiting for each stage ack with a timeout, and latches a sticky error on timeout or ack loss.
module rst_seq_ctrl #(
    parameter int NSTG = 4,
    parameter int DLY  = 4,
    parameter int TMO  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sw_rst,
    input  logic [NSTG-1:0] ack,
    output logic [NSTG-1:0] stg_rst_n,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        ASSERT   = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_t;

    localparam int CMAX = (DLY > TMO) ? DLY : TMO;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NSTG > 1) ? $clog2(NSTG) : 1;

    localparam logic [CW-1:0] ASSERT_END = CW'(DLY - 1);
    localparam logic [CW-1:0] GAP_END    = CW'(DLY);
    localparam logic [CW-1:0] TMO_END    = CW'(TMO - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NSTG - 1);

    logic sync_q1;
    logic rst_sync_n;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [IW-1:0]   idx, idx_d;
    logic [NSTG-1:0] stg_d;
    logic            busy_d, done_d, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            sync_q1    <= 1'b1;
            rst_sync_n <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            stg_rst_n <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            stg_rst_n <= stg_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // The gap after a recognised ack spans one settle edge plus DLY counted edges.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        stg_d   = stg_rst_n;
        busy_d  = busy;
        done_d  = done;
        err_d   = err;

        case (state)
            ASSERT: begin
                stg_d  = '0;
                busy_d = 1'b1;
                done_d = 1'b0;
                err_d  = 1'b0;
                if (!rst_sync_n) begin
                    cnt_d = '0;
                end else if (cnt == ASSERT_END) begin
                    stg_d   = NSTG'(1);
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack[idx]) begin
                    cnt_d = '0;
                    if (idx == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = GAP;
                    end
                end else if (cnt == TMO_END) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    stg_d   = stg_rst_n | (NSTG'(1) << idx);
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                if (ack != '1) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase

        // Any entry into ERR drops every stage and makes the fault sticky.
        if (state_d == ERR) begin
            stg_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b0;
            busy_d = 1'b0;
            cnt_d  = '0;
        end

        if (sw_rst) begin
            state_d = ASSERT;
            stg_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: nominal release table, sw_rst, timeout, ack loss,
// precedence and asynchronous mid-sequence reset.
module tb_rst_seq_ctrl;

    localparam logic [2:0] S_ASSERT = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       sw_rst;
    logic [3:0] ack;
    logic [3:0] ack_en;
    logic [3:0] stg_rst_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         edge_n;
        logic [3:0] stg;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t tbl[13];

    rst_seq_ctrl #(.NSTG(4), .DLY(4), .TMO(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst    (sw_rst),
        .ack       (ack),
        .stg_rst_n (stg_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Stages ack as soon as they are out of reset, unless masked off.
    assign ack = stg_rst_n & ack_en;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] e_stg, input logic e_busy,
                             input logic e_done, input logic e_err);
        check(name, {25'd0, stg_rst_n, busy, done, err}, {25'd0, e_stg, e_busy, e_done, e_err});
    endtask

    task automatic wait_for(input string name, input int bitsel, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step(1);
            n++;
            if ((bitsel == 4) ? done : stg_rst_n[bitsel]) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within %0d edges", name, budget);
    endtask

    // Caller leaves time just after edge E0 with rst_n already released before E1.
    task automatic run_table(input string tag);
        int e = 0;
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].edge_n - e);
            e = tbl[i].edge_n;
            check_out($sformatf("%s_E%0d", tag, tbl[i].edge_n),
                      tbl[i].stg, tbl[i].busy, tbl[i].done, tbl[i].err);
        end
        check($sformatf("%s_state_done", tag), {29'd0, dbg_state}, {29'd0, S_DONE});
    endtask

    task automatic pulse_sw_rst();
        sw_rst = 1'b1;
        step(1);
        sw_rst = 1'b0;
    endtask

    initial begin
        int n;

        tbl[0]  = '{1,  4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2,  4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5,  4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{6,  4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{7,  4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{11, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{12, 4'b0011, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{17, 4'b0011, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{18, 4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{23, 4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{24, 4'b1111, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{25, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{26, 4'b1111, 1'b0, 1'b1, 1'b0};

        rst_n  = 1'b0;
        sw_rst = 1'b0;
        ack_en = 4'b1111;

        // Reset values
        step(2);
        check_out("reset_outputs", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, S_ASSERT});

        // Nominal sequence: rst_n rises 1 ns after E0
        #1;
        rst_n = 1'b1;
        run_table("nominal");

        // sw_rst pulse from DONE
        pulse_sw_rst();
        check_out("swrst_edge", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("swrst_state", {29'd0, dbg_state}, {29'd0, S_ASSERT});
        step(3);
        check_out("swrst_S3", 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1);
        check_out("swrst_S4", 4'b0001, 1'b1, 1'b0, 1'b0);
        wait_for("swrst_done_wait", 4, 60, n);
        check("swrst_done_latency", n, 19);

        // Ack loss in DONE
        ack_en = 4'b1011;
        step(1);
        check_out("ackloss_err", 4'b0000, 1'b0, 1'b0, 1'b1);
        check("ackloss_state", {29'd0, dbg_state}, {29'd0, S_ERR});
        ack_en = 4'b1111;
        step(5);
        check_out("err_sticky", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Timeout on stage 1
        ack_en = 4'b1101;
        pulse_sw_rst();
        check_out("tmo_swrst_clears", 4'b0000, 1'b1, 1'b0, 1'b0);
        wait_for("tmo_stg1_wait", 1, 40, n);
        check("tmo_stg1_latency", n, 10);
        step(63);
        check_out("tmo_R63", 4'b0011, 1'b1, 1'b0, 1'b0);
        step(1);
        check_out("tmo_R64", 4'b0000, 1'b0, 1'b0, 1'b1);
        check("tmo_state", {29'd0, dbg_state}, {29'd0, S_ERR});

        // sw_rst on the timeout edge wins, then held sw_rst keeps ASSERT
        pulse_sw_rst();
        wait_for("prec_stg1_wait", 1, 40, n);
        check("prec_stg1_latency", n, 10);
        step(63);
        check("prec_pre_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
        sw_rst = 1'b1;
        step(1);
        check_out("prec_edge", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("prec_state", {29'd0, dbg_state}, {29'd0, S_ASSERT});
        step(8);
        check_out("swrst_held", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("swrst_held_state", {29'd0, dbg_state}, {29'd0, S_ASSERT});
        sw_rst = 1'b0;
        step(3);
        check_out("held_rel_H3", 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1);
        check_out("held_rel_H4", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in GAP, released 1 ns before the next edge
        ack_en = 4'b1111;
        pulse_sw_rst();
        step(7);
        check("mid_in_gap", {29'd0, dbg_state}, {29'd0, S_GAP});
        check_out("mid_before", 4'b0001, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("mid_async", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("mid_async_state", {29'd0, dbg_state}, {29'd0, S_ASSERT});
        step(2);
        #8;
        rst_n = 1'b1;
        run_table("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
